// File: rtl/xif_alu_coproc.sv
// xif_alu_coproc: eXtension-interface ALU coprocessor (custom-0 R-type).
// Accepted instructions are computed at issue time and parked in a small
// in-order buffer until the core commits or kills them; committed results
// retire from the head in issue order.
// Optional feature: define XIF_COPROC_MUL_EN to enable funct3=3 (MUL low).
module xif_alu_coproc #(
  parameter int DEPTH      = 4,
  parameter int X_ID_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [31:0]           issue_instr_i,
  input  logic [X_ID_WIDTH-1:0] issue_id_i,
  input  logic [31:0]           issue_rs0_i,
  input  logic [31:0]           issue_rs1_i,
  input  logic [1:0]            issue_rs_valid_i,
  output logic                  issue_accept_o,
  output logic                  issue_writeback_o,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [X_ID_WIDTH-1:0] result_id_o,
  output logic [31:0]           result_data_o,
  output logic [4:0]            result_rd_o,
  output logic                  result_we_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ENT_EMPTY,
    ENT_ISSUED,
    ENT_COMMITTED
  } ent_state_t;

  ent_state_t            ent_state [DEPTH];
  logic [X_ID_WIDTH-1:0] ent_id    [DEPTH];
  logic [4:0]            ent_rd    [DEPTH];
  logic [31:0]           ent_data  [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic        opcode_ok;
  logic        funct7_ok;
  logic        op_supported;
  logic [31:0] alu_result;
  logic        full;
  logic        do_issue;
  logic        skip;
  logic        do_pop;
  logic        commit_hit;
  logic [PTR_W-1:0] commit_idx;
  logic [PTR_W-1:0] scan_idx;

  // Register-address fields are not needed: operands arrive by value.
  logic unused_instr_bits;
  assign unused_instr_bits = ^issue_instr_i[24:15];

  // Decode the instruction word and compute the result at issue time.
  always_comb begin
    op_supported = 1'b0;
    alu_result   = 32'd0;
    opcode_ok    = (issue_instr_i[6:0] == 7'h0B);
    funct7_ok    = (issue_instr_i[31:25] == 7'd0);
    case (issue_instr_i[14:12])
      3'd0: begin op_supported = 1'b1; alu_result = issue_rs0_i + issue_rs1_i; end
      3'd1: begin op_supported = 1'b1; alu_result = issue_rs0_i - issue_rs1_i; end
      3'd2: begin op_supported = 1'b1; alu_result = issue_rs0_i ^ issue_rs1_i; end
`ifdef XIF_COPROC_MUL_EN
      3'd3: begin op_supported = 1'b1; alu_result = issue_rs0_i * issue_rs1_i; end
`endif
      default: ;
    endcase
  end

  assign issue_accept_o    = opcode_ok && funct7_ok && op_supported && (issue_rs_valid_i == 2'b11);
  assign issue_writeback_o = issue_accept_o;

  assign full          = (count == CNT_W'(DEPTH));
  assign issue_ready_o = !full;
  assign do_issue      = issue_valid_i && issue_ready_o && issue_accept_o;

  // A squashed entry shows up as EMPTY inside the occupied region.
  assign result_valid_o = (ent_state[head] == ENT_COMMITTED);
  assign skip           = (ent_state[head] == ENT_EMPTY) && (count != '0);
  assign do_pop         = (result_valid_o && result_ready_i) || skip;

  assign result_we_o   = result_valid_o;
  assign result_id_o   = result_valid_o ? ent_id[head]   : '0;
  assign result_data_o = result_valid_o ? ent_data[head] : 32'd0;
  assign result_rd_o   = result_valid_o ? ent_rd[head]   : 5'd0;

  // Find the oldest ISSUED entry whose ID matches the commit, scanning from head.
  always_comb begin
    commit_hit = 1'b0;
    commit_idx = '0;
    scan_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head + PTR_W'(k);
      if (!commit_hit && commit_valid_i && (CNT_W'(k) < count) &&
          (ent_state[scan_idx] == ENT_ISSUED) && (ent_id[scan_idx] == commit_id_i)) begin
        commit_hit = 1'b1;
        commit_idx = scan_idx;
      end
    end
  end

  // Buffer state: allocate at tail, commit/kill in place, retire or skip at head.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_state[i] <= ENT_EMPTY;
        ent_id[i]    <= '0;
        ent_rd[i]    <= 5'd0;
        ent_data[i]  <= 32'd0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_issue) begin
        ent_state[tail] <= ENT_ISSUED;
        ent_id[tail]    <= issue_id_i;
        ent_rd[tail]    <= issue_instr_i[11:7];
        ent_data[tail]  <= alu_result;
        tail            <= tail + PTR_W'(1);
      end
      if (commit_hit) begin
        ent_state[commit_idx] <= commit_kill_i ? ENT_EMPTY : ENT_COMMITTED;
      end
      if (do_pop) begin
        ent_state[head] <= ENT_EMPTY;
        head            <= head + PTR_W'(1);
      end
      case ({do_issue, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xif_alu_coproc.sv
// Self-checking bench for xif_alu_coproc using directed vectors.
// Expectations for funct3=3 follow the XIF_COPROC_MUL_EN macro.
module tb_xif_alu_coproc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_instr;
  logic [3:0]  issue_id;
  logic [31:0] issue_rs0;
  logic [31:0] issue_rs1;
  logic [1:0]  issue_rs_valid;
  logic        issue_accept;
  logic        issue_writeback;
  logic        commit_valid;
  logic [3:0]  commit_id;
  logic        commit_kill;
  logic        result_valid;
  logic        result_ready;
  logic [3:0]  result_id;
  logic [31:0] result_data;
  logic [4:0]  result_rd;
  logic        result_we;

  int vectors = 0;
  int miscompares = 0;

  xif_alu_coproc #(.DEPTH(4), .X_ID_WIDTH(4)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .issue_valid_i    (issue_valid),
    .issue_ready_o    (issue_ready),
    .issue_instr_i    (issue_instr),
    .issue_id_i       (issue_id),
    .issue_rs0_i      (issue_rs0),
    .issue_rs1_i      (issue_rs1),
    .issue_rs_valid_i (issue_rs_valid),
    .issue_accept_o   (issue_accept),
    .issue_writeback_o(issue_writeback),
    .commit_valid_i   (commit_valid),
    .commit_id_i      (commit_id),
    .commit_kill_i    (commit_kill),
    .result_valid_o   (result_valid),
    .result_ready_i   (result_ready),
    .result_id_o      (result_id),
    .result_data_o    (result_data),
    .result_rd_o      (result_rd),
    .result_we_o      (result_we)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] opc);
    return {f7, 10'd0, f3, rd, opc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic [2:0] f3, input logic [4:0] rd, input logic [3:0] id,
                             input logic [31:0] a, input logic [31:0] b);
    issue_valid    = 1'b1;
    issue_instr    = enc(7'd0, f3, rd, 7'h0B);
    issue_id       = id;
    issue_rs0      = a;
    issue_rs1      = b;
    issue_rs_valid = 2'b11;
  endtask

  task automatic clear_issue();
    issue_valid    = 1'b0;
    issue_rs_valid = 2'b00;
  endtask

  task automatic drive_commit(input logic [3:0] id, input logic kill);
    commit_valid = 1'b1;
    commit_id    = id;
    commit_kill  = kill;
  endtask

  task automatic clear_commit();
    commit_valid = 1'b0;
    commit_kill  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    result_ready = 1'b0;
    clear_commit();
    commit_id    = 4'd0;
    drive_issue(3'd0, 5'd1, 4'd0, 32'd1, 32'd1);
    issue_valid  = 1'b0;
    tick();
    tick();
    #1;
    vectors++;
    if (issue_accept !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_accept: got %b want 1", issue_accept); end
    vectors++;
    if (issue_writeback !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_writeback: got %b want 1", issue_writeback); end
    issue_rs_valid = 2'b10;
    #1;
    vectors++;
    if (issue_accept !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_accept_rsv: got %b want 0", issue_accept); end
    clear_issue();
    rst_n = 1'b1;
    #1;
    vectors++;
    if (issue_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b want 1", issue_ready); end
    vectors++;
    if (result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b want 0", result_valid); end
    vectors++;
    if ({result_id, result_data, result_rd, result_we} !== 42'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got id=%h data=%h rd=%h we=%b want all 0", result_id, result_data, result_rd, result_we);
    end
    tick();
  endtask

  task automatic test_add();
    drive_issue(3'd0, 5'd5, 4'd1, 32'hFFFF_FFFF, 32'd2);
    #1;
    vectors++;
    if (issue_accept !== 1'b1) begin miscompares++; $display("[TB] FAIL add_accept: got %b want 1", issue_accept); end
    tick();
    clear_issue();
    drive_commit(4'd1, 1'b0);
    #1;
    vectors++;
    if (result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL add_valid_early: got %b want 0", result_valid); end
    tick();
    clear_commit();
    #1;
    vectors++;
    if (result_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL add_valid: got %b want 1", result_valid); end
    vectors++;
    if (result_data !== 32'h1) begin miscompares++; $display("[TB] FAIL add_data: got %h want 00000001", result_data); end
    vectors++;
    if (result_id !== 4'd1 || result_we !== 1'b1 || result_rd !== 5'd5) begin
      miscompares++;
      $display("[TB] FAIL add_meta: got id=%0d we=%b rd=%0d want id=1 we=1 rd=5", result_id, result_we, result_rd);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    #1;
    vectors++;
    if (result_valid !== 1'b0 || result_data !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL add_after_pop: got valid=%b data=%h want 0/0", result_valid, result_data);
    end
    tick();
  endtask

  task automatic test_alu_ops();
    drive_issue(3'd1, 5'd6, 4'd2, 32'd5, 32'd7);
    tick();
    drive_issue(3'd2, 5'd8, 4'd3, 32'hA5A5_A5A5, 32'hFFFF_0000);
    tick();
    clear_issue();
    drive_commit(4'd2, 1'b0);
    tick();
    drive_commit(4'd3, 1'b0);
    result_ready = 1'b1;
    #1;
    vectors++;
    if (result_valid !== 1'b1 || result_id !== 4'd2 || result_data !== 32'hFFFF_FFFE || result_rd !== 5'd6) begin
      miscompares++;
      $display("[TB] FAIL sub_result: got v=%b id=%0d data=%h rd=%0d want 1/2/fffffffe/6", result_valid, result_id, result_data, result_rd);
    end
    tick();
    clear_commit();
    #1;
    vectors++;
    if (result_valid !== 1'b1 || result_id !== 4'd3 || result_data !== 32'h5A5A_A5A5 || result_rd !== 5'd8) begin
      miscompares++;
      $display("[TB] FAIL xor_result: got v=%b id=%0d data=%h rd=%0d want 1/3/5a5aa5a5/8", result_valid, result_id, result_data, result_rd);
    end
    tick();
    result_ready = 1'b0;
    #1;
    vectors++;
    if (result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL ops_drained: got %b want 0", result_valid); end
    tick();
  endtask

  task automatic test_reject();
    logic [31:0] instrs [5];
    logic [1:0]  rsvs   [5];
    instrs[0] = enc(7'd0,  3'd0, 5'd1, 7'h0B); rsvs[0] = 2'b01;
    instrs[1] = enc(7'd0,  3'd0, 5'd1, 7'h0B); rsvs[1] = 2'b10;
    instrs[2] = enc(7'd1,  3'd0, 5'd1, 7'h0B); rsvs[2] = 2'b11;
    instrs[3] = enc(7'd0,  3'd0, 5'd1, 7'h33); rsvs[3] = 2'b11;
    instrs[4] = enc(7'd0,  3'd4, 5'd1, 7'h0B); rsvs[4] = 2'b11;
    for (int i = 0; i < 5; i++) begin
      issue_valid    = 1'b1;
      issue_instr    = instrs[i];
      issue_rs_valid = rsvs[i];
      issue_id       = 4'd7;
      issue_rs0      = 32'd1;
      issue_rs1      = 32'd1;
      #1;
      vectors++;
      if (issue_accept !== 1'b0 || issue_writeback !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reject_%0d: got accept=%b wb=%b want 0/0", i, issue_accept, issue_writeback);
      end
      tick();
    end
    clear_issue();
    drive_commit(4'd7, 1'b0);
    tick();
    clear_commit();
    #1;
    vectors++;
    if (result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reject_no_entry: got %b want 0", result_valid); end
    tick();
  endtask

  task automatic test_mul();
    logic exp_acc;
`ifdef XIF_COPROC_MUL_EN
    exp_acc = 1'b1;
`else
    exp_acc = 1'b0;
`endif
    drive_issue(3'd3, 5'd9, 4'd4, 32'd3, 32'd5);
    #1;
    vectors++;
    if (issue_accept !== exp_acc) begin miscompares++; $display("[TB] FAIL mul_accept: got %b want %b", issue_accept, exp_acc); end
    tick();
    clear_issue();
    drive_commit(4'd4, 1'b0);
    tick();
    clear_commit();
    #1;
    vectors++;
    if (result_valid !== exp_acc) begin miscompares++; $display("[TB] FAIL mul_valid: got %b want %b", result_valid, exp_acc); end
    vectors++;
    if (result_data !== (exp_acc ? 32'd15 : 32'd0)) begin
      miscompares++;
      $display("[TB] FAIL mul_data: got %h want %h", result_data, exp_acc ? 32'd15 : 32'd0);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      drive_issue(3'd0, 5'd2, 4'(i), 32'(i), 32'd0);
      #1;
      vectors++;
      if (issue_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL full_fill_ready_%0d: got %b want 1", i, issue_ready); end
      tick();
    end
    drive_issue(3'd0, 5'd2, 4'd9, 32'd9, 32'd0);
    #1;
    vectors++;
    if (issue_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL full_ready: got %b want 0", issue_ready); end
    tick();
    clear_issue();
    drive_commit(4'd0, 1'b0);
    tick();
    clear_commit();
    result_ready = 1'b1;
    #1;
    vectors++;
    if (result_valid !== 1'b1 || result_id !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL full_head_result: got v=%b id=%0d want 1/0", result_valid, result_id);
    end
    vectors++;
    if (issue_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL full_no_bypass: got %b want 0", issue_ready); end
    tick();
    result_ready = 1'b0;
    #1;
    vectors++;
    if (issue_ready !== 1'b1 || result_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_after_pop: got ready=%b valid=%b want 1/0", issue_ready, result_valid);
    end
    drive_commit(4'd9, 1'b0);
    tick();
    for (int i = 1; i < 4; i++) begin
      drive_commit(4'(i), 1'b1);
      tick();
    end
    clear_commit();
    result_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL full_squash_%0d: got valid=%b want 0", i, result_valid); end
      tick();
    end
    result_ready = 1'b0;
  endtask

  task automatic test_kill();
    drive_issue(3'd0, 5'd3, 4'd2, 32'd40, 32'd2);
    tick();
    drive_issue(3'd0, 5'd4, 4'd3, 32'd50, 32'd3);
    tick();
    clear_issue();
    drive_commit(4'd2, 1'b1);
    tick();
    drive_commit(4'd3, 1'b0);
    result_ready = 1'b1;
    #1;
    vectors++;
    if (result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL kill_skip: got valid=%b want 0", result_valid); end
    tick();
    clear_commit();
    #1;
    vectors++;
    if (result_valid !== 1'b1 || result_id !== 4'd3 || result_data !== 32'd53) begin
      miscompares++;
      $display("[TB] FAIL kill_survivor: got v=%b id=%0d data=%0d want 1/3/53", result_valid, result_id, result_data);
    end
    tick();
    #1;
    vectors++;
    if (result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL kill_drained: got %b want 0", result_valid); end
    result_ready = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    drive_issue(3'd0, 5'd7, 4'd5, 32'd10, 32'd20);
    tick();
    clear_issue();
    drive_commit(4'd5, 1'b0);
    tick();
    clear_commit();
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (result_valid !== 1'b1 || result_data !== 32'd30 || result_id !== 4'd5 || result_rd !== 5'd7) begin
        miscompares++;
        $display("[TB] FAIL stall_hold_%0d: got v=%b data=%0d id=%0d rd=%0d want 1/30/5/7", i, result_valid, result_data, result_id, result_rd);
      end
      tick();
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    #1;
    vectors++;
    if (result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_single_pop: got %b want 0", result_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    drive_issue(3'd0, 5'd10, 4'd6, 32'd60, 32'd0);
    tick();
    drive_issue(3'd0, 5'd11, 4'd7, 32'd70, 32'd0);
    tick();
    clear_issue();
    drive_commit(4'd6, 1'b0);
    tick();
    drive_issue(3'd0, 5'd12, 4'd8, 32'd80, 32'd0);
    drive_commit(4'd7, 1'b0);
    result_ready = 1'b1;
    #1;
    vectors++;
    if (result_valid !== 1'b1 || result_id !== 4'd6 || result_data !== 32'd60) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got v=%b id=%0d data=%0d want 1/6/60", result_valid, result_id, result_data);
    end
    tick();
    clear_issue();
    clear_commit();
    #1;
    vectors++;
    if (result_valid !== 1'b1 || result_id !== 4'd7 || result_data !== 32'd70) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got v=%b id=%0d data=%0d want 1/7/70", result_valid, result_id, result_data);
    end
    tick();
    drive_commit(4'd8, 1'b0);
    #1;
    vectors++;
    if (result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_third_early: got %b want 0", result_valid); end
    tick();
    clear_commit();
    #1;
    vectors++;
    if (result_valid !== 1'b1 || result_id !== 4'd8 || result_data !== 32'd80 || result_rd !== 5'd12) begin
      miscompares++;
      $display("[TB] FAIL b2b_third: got v=%b id=%0d data=%0d rd=%0d want 1/8/80/12", result_valid, result_id, result_data, result_rd);
    end
    tick();
    result_ready = 1'b0;
    tick();
  endtask

  task automatic test_commit_match();
    drive_issue(3'd0, 5'd1, 4'd10, 32'd100, 32'd0);
    tick();
    drive_issue(3'd0, 5'd1, 4'd10, 32'd200, 32'd0);
    tick();
    clear_issue();
    drive_commit(4'd10, 1'b0);
    tick();
    result_ready = 1'b1;
    #1;
    vectors++;
    if (result_valid !== 1'b1 || result_data !== 32'd100) begin
      miscompares++;
      $display("[TB] FAIL dup_oldest: got v=%b data=%0d want 1/100", result_valid, result_data);
    end
    tick();
    #1;
    vectors++;
    if (result_valid !== 1'b1 || result_data !== 32'd200) begin
      miscompares++;
      $display("[TB] FAIL dup_second: got v=%b data=%0d want 1/200", result_valid, result_data);
    end
    tick();
    clear_commit();
    drive_issue(3'd0, 5'd1, 4'd9, 32'd90, 32'd0);
    drive_commit(4'd9, 1'b0);
    tick();
    clear_issue();
    clear_commit();
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL same_cycle_commit_%0d: got %b want 0", i, result_valid); end
      tick();
    end
    drive_commit(4'd9, 1'b1);
    tick();
    clear_commit();
    tick();
    result_ready = 1'b0;
    #1;
    vectors++;
    if (result_valid !== 1'b0 || issue_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL match_drained: got valid=%b ready=%b want 0/1", result_valid, issue_ready);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    drive_issue(3'd0, 5'd1, 4'd1, 32'd11, 32'd0);
    tick();
    drive_issue(3'd0, 5'd2, 4'd2, 32'd22, 32'd0);
    tick();
    clear_issue();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    vectors++;
    if (result_valid !== 1'b0 || issue_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_state: got valid=%b ready=%b want 0/1", result_valid, issue_ready);
    end
    drive_commit(4'd1, 1'b0);
    tick();
    drive_commit(4'd2, 1'b0);
    #1;
    vectors++;
    if (result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_commit1: got %b want 0", result_valid); end
    tick();
    clear_commit();
    #1;
    vectors++;
    if (result_valid !== 1'b0 || result_data !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_commit2: got valid=%b data=%h want 0/0", result_valid, result_data);
    end
    tick();
  endtask

  // Run every scenario in order, then report.
  initial begin
    issue_valid    = 1'b0;
    issue_instr    = 32'd0;
    issue_id       = 4'd0;
    issue_rs0      = 32'd0;
    issue_rs1      = 32'd0;
    issue_rs_valid = 2'b00;
    commit_valid   = 1'b0;
    commit_id      = 4'd0;
    commit_kill    = 1'b0;
    result_ready   = 1'b0;
    rst_n          = 1'b0;
    test_reset();
    test_add();
    test_alu_ops();
    test_reject();
    test_mul();
    test_full();
    test_kill();
    test_stall();
    test_back_to_back();
    test_commit_match();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/xif_alu_coproc.md
XIF_ALU_COPROC -- requirements
Module: xif_alu_coproc

Interface
REQ-001 Parameter DEPTH, default 4: number of outstanding-instruction buffer entries, power of two, 2..16.
REQ-002 Parameter X_ID_WIDTH, default 4: width of the eXtension instruction ID.
REQ-003 Port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_ni, input, 1: synchronous, active-low reset, sampled on rising clk_i.
REQ-005 Port issue_valid_i, input, 1: core offers an instruction.
REQ-006 Port issue_ready_o, output, 1: block accepts the issue handshake.
REQ-007 Port issue_instr_i / issue_id_i / issue_rs0_i / issue_rs1_i / issue_rs_valid_i, input, 32/X_ID_WIDTH/32/32/2: instruction word, ID, operands, operand-valid flags.
REQ-008 Port issue_accept_o / issue_writeback_o, output, 1/1: offload accepted; result will be written to rd.
REQ-009 Port commit_valid_i / commit_id_i / commit_kill_i, input, 1/X_ID_WIDTH/1: commit or kill of an issued ID.
REQ-010 Port result_valid_o / result_ready_i, output/input, 1/1: result handshake.
REQ-011 Port result_id_o / result_data_o / result_rd_o / result_we_o, output, X_ID_WIDTH/32/5/1: result ID, value, destination register, write enable.

Function
REQ-012 The block SHALL decode opcode 7'h0B (custom-0), R-type; funct3 0 = rs0+rs1, 1 = rs0-rs1, 2 = rs0^rs1, 3 = MUL low 32 bits (see REQ-030); funct7 must be 0; all arithmetic modulo 2^32.
REQ-013 issue_ready_o SHALL be 1 when the buffer is not full, else 0, independent of instruction content.
REQ-014 issue_accept_o and issue_writeback_o SHALL be combinational, 1 only for a supported encoding with issue_rs_valid_i==2'b11, else 0.
REQ-015 The block SHALL treat an issue with a supported encoding but issue_rs_valid_i!=2'b11 as not accepted; no entry is allocated.
REQ-016 On issue_valid_i && issue_ready_o && issue_accept_o, the block SHALL compute the result and write {id, rd, data, committed=0} into the tail entry in the same cycle.
REQ-017 Entry states: EMPTY -> ISSUED (accepted issue) -> COMMITTED (commit, kill=0) -> EMPTY (result handshake); ISSUED -> EMPTY (commit, kill=1).
REQ-018 Commit SHALL match the oldest ISSUED entry with equal ID; commit for an unknown ID, or an ID issued in the same cycle, SHALL be ignored.
REQ-019 Killed entries SHALL be squashed in place; the head SHALL skip squashed entries at one entry per cycle without asserting result_valid_o.
REQ-020 result_valid_o SHALL be 1 iff the head entry is COMMITTED; results SHALL leave in issue order.
REQ-021 Latency: commit in cycle M of the head entry SHALL give result_valid_o=1 in cycle M+1.
REQ-022 While result_valid_o=1 && result_ready_i=0, all result outputs SHALL hold stable.
REQ-023 result_we_o SHALL equal 1 whenever result_valid_o=1; result outputs SHALL be 0 when result_valid_o=0.
REQ-024 Simultaneous issue, commit and result handshake in one cycle SHALL all take effect; full buffer with same-cycle result pop SHALL still report issue_ready_o=0 (no bypass).
REQ-025 The occupancy counter SHALL count 0..DEPTH; head and tail pointers SHALL wrap modulo DEPTH.

Reset
REQ-026 With rst_ni=0 at a rising edge, all entries SHALL become EMPTY and pointers and counter SHALL become 0.
REQ-027 Outputs after reset: issue_ready_o=1, result_valid_o=0, result_id_o=0, result_data_o=0, result_rd_o=0, result_we_o=0.
REQ-028 Reset mid-operation SHALL drop all outstanding entries without emitting results.
REQ-029 Combinational issue_accept_o/issue_writeback_o SHALL follow REQ-014 during reset.

Configuration
REQ-030 Macro XIF_COPROC_MUL_EN defined: funct3=3 SHALL be accepted and return (rs0*rs1)[31:0]; undefined: funct3=3 SHALL give issue_accept_o=0 and no multiplier SHALL be synthesized.

Verification
REQ-031 Issue ADD id=1, rs0=32'hFFFF_FFFF, rs1=2, commit id=1 kill=0 -> result_valid_o next cycle, data=32'h1, id=1, we=1.
REQ-032 Issue funct3=3, rs0=3, rs1=5 -> with XIF_COPROC_MUL_EN accept=1, result 15; without it accept=0, no result.
REQ-033 Issue ids 0..3 (DEPTH=4), no commit -> issue_ready_o=0; commit id0 then ready pop -> issue_ready_o=1 next cycle.
REQ-034 Issue ids 2,3; kill id2, commit id3 -> only id3 result emitted, in order.
REQ-035 Committed result with result_ready_i=0 for 5 cycles -> outputs stable, then single handshake.
REQ-036 Two outstanding entries, rst_ni=0 one cycle -> result_valid_o=0, issue_ready_o=1, later commits ignored.
